// File: rtl/pwm_pkg.sv
// pwm_pkg: mode encodings and width helper shared by the multi-channel PWM driver.
package pwm_pkg;
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_CONST   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_CHASE   = 2'b11;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one LED channel; folds the shared phase into a triangle level and
// compares it against the frame counter to produce a registered drive bit.
module pwm_chan import pwm_pkg::*; #(
  parameter int STEPS = 100,
  parameter int UNIT  = 10,
  parameter int OFS   = 0,
  parameter int LVL_W = 7,
  parameter int PH_W  = 8,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [LVL_W-1:0] duty,
  input  logic [PH_W-1:0]  phase,
  input  logic [CNT_W-1:0] cnt,
  output logic             led
);
  localparam int PW = PH_W + 1;
  logic [PW-1:0] sum, p;
  logic [LVL_W-1:0] level;
  logic led_d, led_q;
  always_comb begin
    sum = {1'b0, phase} + (mode == MODE_CHASE ? PW'(OFS) : '0);
    p = sum >= PW'(2*STEPS) ? sum - PW'(2*STEPS) : sum;
    level = mode == MODE_OFF ? '0
          : mode == MODE_CONST ? (duty > LVL_W'(STEPS) ? LVL_W'(STEPS) : duty)
          : LVL_W'(p <= PW'(STEPS) ? p : PW'(2*STEPS) - p);
    led_d = en && (int'(cnt) < int'(level) * UNIT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) led_q <= 1'b0;
    else led_q <= led_d;
  assign led = led_q;
endmodule

// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi: N-channel PWM LED driver with off, constant, breathe and
// phase-staggered chase modes sharing one frame counter and breathe phase.
module pwm_breathe_multi import pwm_pkg::*; #(
  parameter int N_CH            = 15,
  parameter int STEPS           = 100,
  parameter int UNIT            = 10,
  parameter int FRAMES_PER_STEP = 500,
  parameter int PH_OFF          = 13,
  localparam int LVL_W          = clog2(STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [LVL_W-1:0] duty,
  output logic [N_CH-1:0]  led,
  output logic             step_tick,
  output logic             dir
);
  localparam int PH_W  = clog2(2*STEPS);
  localparam int CNT_W = clog2(STEPS*UNIT);
  localparam int FR_W  = clog2(FRAMES_PER_STEP);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [1:0] mode_q, mode_d;
  logic [LVL_W-1:0] duty_q, duty_d;
  logic step_tick_q, step_tick_d, dir_q, dir_d, frame_end, run, wrap;
  always_comb begin
    frame_end = cnt_q == CNT_W'(STEPS*UNIT-1);
    run = mode_q == MODE_BREATHE || mode_q == MODE_CHASE;
    wrap = frame_end && run && frame_cnt_q == FR_W'(FRAMES_PER_STEP-1);
    cnt_d = (!en || frame_end) ? '0 : cnt_q + 1'b1;
    frame_cnt_d = (!en || wrap) ? '0 : (frame_end && run) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    phase_d = !en ? '0 : !wrap ? phase_q : phase_q == PH_W'(2*STEPS-1) ? '0 : phase_q + 1'b1;
    mode_d = (!en || frame_end) ? mode : mode_q;
    duty_d = (!en || frame_end) ? duty : duty_q;
    step_tick_d = en && wrap;
    dir_d = phase_d < PH_W'(STEPS);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      phase_q     <= '0;
      mode_q      <= MODE_OFF;
      duty_q      <= '0;
      step_tick_q <= 1'b0;
      dir_q       <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      duty_q      <= duty_d;
      step_tick_q <= step_tick_d;
      dir_q       <= dir_d;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_chan #(
      .STEPS(STEPS), .UNIT(UNIT), .OFS((i*PH_OFF) % (2*STEPS)),
      .LVL_W(LVL_W), .PH_W(PH_W), .CNT_W(CNT_W)
    ) u_chan (
      .clk(clk), .rst(rst), .en(en), .mode(mode_q), .duty(duty_q),
      .phase(phase_q), .cnt(cnt_q), .led(led[i])
    );
  end
  assign step_tick = step_tick_q;
  assign dir = dir_q;
endmodule

// File: tb/tb_pwm_breathe_multi.sv
// tb_pwm_breathe_multi: scenario tasks plus randomized run against a
// frame-level behavioural model of the multi-channel PWM driver.
module tb_pwm_breathe_multi;
  localparam int S = 4, U = 2, FPS = 1, PO = 2, NC = 4;
  logic clk = 0, rst = 1, en = 1;
  logic [1:0] mode = 0;
  logic [2:0] duty = 0;
  logic [3:0] led;
  logic step_tick, dir;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_fc = 0, m_phase = 0, m_mode = 0, m_duty = 0, m_lcnt = -1;
  logic [3:0] m_led = 0;
  logic m_tick = 0, m_dir = 1, m_adv;

  pwm_breathe_multi #(.N_CH(NC), .STEPS(S), .UNIT(U), .FRAMES_PER_STEP(FPS), .PH_OFF(PO)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .duty(duty),
    .led(led), .step_tick(step_tick), .dir(dir)
  );

  always #5 clk = ~clk;
  initial begin #400000; $display("FAIL watchdog timeout"); $fatal(1, "timeout"); end

  function automatic int lvl_of(int ch, int ph, int md, int du);
    int p;
    if (md == 0) return 0;
    if (md == 1) return du > S ? S : du;
    p = (md == 3) ? (ph + ch * PO) % (2 * S) : ph;
    return p <= S ? p : 2 * S - p;
  endfunction

  assign m_adv = (m_cnt == S * U - 1) && (m_mode >= 2) && ((m_fc + 1) % FPS == 0);

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_cnt <= 0; m_fc <= 0; m_phase <= 0; m_mode <= 0; m_duty <= 0;
      m_led <= 0; m_tick <= 0; m_dir <= 1; m_lcnt <= -1;
    end else if (!en) begin
      m_cnt <= 0; m_fc <= 0; m_phase <= 0; m_mode <= int'(mode); m_duty <= int'(duty);
      m_led <= 0; m_tick <= 0; m_dir <= 1; m_lcnt <= -1;
    end else begin
      for (int c = 0; c < NC; c++) m_led[c] <= m_cnt < lvl_of(c, m_phase, m_mode, m_duty) * U;
      m_lcnt <= m_cnt;
      m_cnt <= (m_cnt + 1) % (S * U);
      if (m_cnt == S * U - 1) begin m_mode <= int'(mode); m_duty <= int'(duty); end
      if (m_cnt == S * U - 1 && m_mode >= 2) m_fc <= (m_fc + 1) % FPS;
      m_tick <= m_adv;
      m_phase <= m_adv ? (m_phase + 1) % (2 * S) : m_phase;
      m_dir <= (m_adv ? (m_phase + 1) % (2 * S) : m_phase) < S;
    end

  // Gathers one output frame (aligned to the model's led-frame start); optionally
  // changes mode/duty at cycle chg_at of the frame.
  task automatic measure_frame(input int chg_at, input int nm, input int nd,
                               output int lit[4], output int mlit[4],
                               output int ticks, output int bad, output int d0);
    int w = 0;
    for (int c = 0; c < 4; c++) begin lit[c] = 0; mlit[c] = 0; end
    ticks = 0; bad = 0; d0 = 0;
    @(negedge clk);
    while (m_lcnt != 0 && w < 20) begin @(negedge clk); w++; end
    if (w == 20) begin
      checks++; errors++;
      $display("FAIL frame_sync lcnt=%0d expected 0", m_lcnt);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) d0 = int'(dir);
      if (k == chg_at) begin mode = 2'(nm); duty = 3'(nd); end
      for (int c = 0; c < 4; c++) begin lit[c] += int'(led[c]); mlit[c] += int'(m_led[c]); end
      ticks += int'(step_tick);
      if (led !== m_led || step_tick !== m_tick || dir !== m_dir) bad++;
    end
  endtask

  task automatic test_reset;
    int lit[4], mlit[4], tk, bad, d0;
    int exp_a[4], exp_b[3];
    exp_a = '{0, 0, 2, 4};
    exp_b = '{0, 0, 2};
    rst = 1; en = 1; mode = 2; duty = 0;
    #2 rst = 0;
    #1;
    checks += 3;
    if (led !== 4'h0) begin errors++; $display("FAIL reset_led got=%h exp=0", led); end
    if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b exp=1", dir); end
    if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", step_tick); end
    repeat (2) @(negedge clk);
    rst = 1;
    for (int f = 0; f < 4; f++) begin
      measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
      checks += 2;
      if (bad !== 0) begin errors++; $display("FAIL reset_run_cycles frame%0d bad=%0d exp=0", f, bad); end
      if (lit[0] !== exp_a[f] || lit[3] !== exp_a[f])
        begin errors++; $display("FAIL reset_run_lit frame%0d got=%0d,%0d exp=%0d", f, lit[0], lit[3], exp_a[f]); end
    end
    @(negedge clk);
    checks++;
    if (led !== 4'hF) begin errors++; $display("FAIL pre_drop_led got=%h exp=f", led); end
    #2 rst = 0;
    #1;
    checks += 3;
    if (led !== 4'h0) begin errors++; $display("FAIL async_led got=%h exp=0", led); end
    if (dir !== 1'b1) begin errors++; $display("FAIL async_dir got=%b exp=1", dir); end
    if (step_tick !== 1'b0) begin errors++; $display("FAIL async_tick got=%b exp=0", step_tick); end
    @(negedge clk);
    rst = 1;
    for (int f = 0; f < 3; f++) begin
      measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
      checks += 2;
      if (bad !== 0) begin errors++; $display("FAIL restart_cycles frame%0d bad=%0d exp=0", f, bad); end
      if (lit[1] !== exp_b[f]) begin errors++; $display("FAIL restart_lit frame%0d got=%0d exp=%0d", f, lit[1], exp_b[f]); end
    end
  endtask

  task automatic test_const;
    int lit[4], mlit[4], tk, bad, d0;
    int dv[4], ev[4];
    dv = '{3, 7, 0, 3};
    ev = '{6, 8, 0, 6};
    mode = 1;
    for (int t = 0; t < 4; t++) begin
      duty = 3'(dv[t]);
      measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
      measure_frame(t == 3 ? 3 : -1, 1, 1, lit, mlit, tk, bad, d0);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL const_cycles duty=%0d bad=%0d exp=0", dv[t], bad); end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (lit[c] !== ev[t]) begin errors++; $display("FAIL const_lit duty=%0d ch%0d got=%0d exp=%0d", dv[t], c, lit[c], ev[t]); end
      end
    end
    measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (lit[c] !== 2) begin errors++; $display("FAIL const_midchange_next ch%0d got=%0d exp=2", c, lit[c]); end
    end
  endtask

  task automatic test_breathe;
    int lit[4], mlit[4], tk, bad, d0;
    int tri_t[8];
    tri_t = '{0, 2, 4, 6, 8, 6, 4, 2};
    @(negedge clk); en = 0; mode = 2;
    repeat (2) @(negedge clk);
    en = 1;
    for (int f = 0; f < 9; f++) begin
      measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
      checks += 3;
      if (bad !== 0) begin errors++; $display("FAIL breathe_cycles frame%0d bad=%0d exp=0", f, bad); end
      if (tk !== 1) begin errors++; $display("FAIL breathe_tick frame%0d got=%0d exp=1", f, tk); end
      if (d0 !== int'(f % 8 < 4)) begin errors++; $display("FAIL breathe_dir frame%0d got=%0d exp=%0d", f, d0, int'(f % 8 < 4)); end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (lit[c] !== tri_t[f % 8]) begin errors++; $display("FAIL breathe_lit frame%0d ch%0d got=%0d exp=%0d", f, c, lit[c], tri_t[f % 8]); end
      end
    end
  endtask

  task automatic test_chase;
    int lit[4], mlit[4], tk, bad, d0;
    int e0[4], e1[4], e4[4];
    e0 = '{0, 4, 8, 4};
    e1 = '{2, 6, 6, 2};
    e4 = '{8, 4, 0, 4};
    @(negedge clk); en = 0; mode = 3;
    repeat (2) @(negedge clk);
    en = 1;
    for (int f = 0; f < 5; f++) begin
      measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL chase_cycles frame%0d bad=%0d exp=0", f, bad); end
      for (int c = 0; c < 4; c++) begin
        if (f == 0 || f == 1 || f == 4) begin
          checks++;
          if (lit[c] !== (f == 0 ? e0[c] : f == 1 ? e1[c] : e4[c]))
            begin errors++; $display("FAIL chase_lit frame%0d ch%0d got=%0d exp=%0d", f, c, lit[c], f == 0 ? e0[c] : f == 1 ? e1[c] : e4[c]); end
        end
      end
    end
  endtask

  task automatic test_enable;
    int lit[4], mlit[4], tk, bad, d0;
    int ev[7];
    ev = '{0, 2, 4, 0, 0, 0, 6};
    @(negedge clk); en = 0; mode = 2;
    repeat (2) @(negedge clk);
    en = 1;
    for (int f = 0; f < 4; f++) measure_frame(-1, 0, 0, lit, mlit, tk, bad, d0);
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 4'hF) begin errors++; $display("FAIL en_pre_led got=%h exp=f", led); end
    en = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (led !== 4'h0) begin errors++; $display("FAIL en_off_led cycle%0d got=%h exp=0", k, led); end
      if (dir !== 1'b1) begin errors++; $display("FAIL en_off_dir cycle%0d got=%b exp=1", k, dir); end
    end
    en = 1;
    for (int f = 0; f < 7; f++) begin
      if (f == 5) mode = 2;
      measure_frame(f == 2 ? 3 : -1, 0, 0, lit, mlit, tk, bad, d0);
      checks += 2;
      if (bad !== 0) begin errors++; $display("FAIL en_mode_cycles frame%0d bad=%0d exp=0", f, bad); end
      if (lit[2] !== ev[f]) begin errors++; $display("FAIL en_mode_lit frame%0d got=%0d exp=%0d", f, lit[2], ev[f]); end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks += 3;
      if (led !== m_led) begin errors++; $display("FAIL rand_led cycle%0d got=%h exp=%h", k, led, m_led); end
      if (step_tick !== m_tick) begin errors++; $display("FAIL rand_tick cycle%0d got=%b exp=%b", k, step_tick, m_tick); end
      if (dir !== m_dir) begin errors++; $display("FAIL rand_dir cycle%0d got=%b exp=%b", k, dir, m_dir); end
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) duty = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 60) != 0);
    end
    en = 1;
  endtask

  initial begin
    test_reset;
    test_const;
    test_breathe;
    test_chase;
    test_enable;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
